// File: rtl/text_pkg.sv
// Shared types and constants for the text-sprite fetch scheduler.
package text_pkg;

    typedef enum logic [1:0] {
        IDLE,
        CP,
        GLYPH
    } state_t;

    localparam int CP_START    = 'h20;
    localparam int FONT_HEIGHT = 8;
    localparam int NUM_GLYPHS  = 64;

    function automatic int greet_aw(input int msgs, input int len);
        return $clog2(msgs * len);
    endfunction

    function automatic int font_aw(input int glyphs, input int height);
        return $clog2(glyphs * height);
    endfunction

endpackage

// File: rtl/msg_pacer.sv
// Frame counter that steps the greeting index every TXT_PAUSE frames.
module msg_pacer #(
    parameter int GREET_MSGS = 32,
    parameter int TXT_PAUSE  = 80
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          frame_start,
    input  logic                          hold,
    output logic [$clog2(GREET_MSGS)-1:0] greeting
);

    localparam int GW = $clog2(GREET_MSGS);
    localparam int FW = $clog2(TXT_PAUSE + 1);
    localparam logic [FW-1:0] LAST_FRM = FW'(TXT_PAUSE - 1);
    localparam logic [GW-1:0] LAST_MSG = GW'(GREET_MSGS - 1);

    logic [FW-1:0] cnt_frm;

    // cnt_frm parks on LAST_FRM while hold is high
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_frm  <= '0;
            greeting <= '0;
        end else if (frame_start) begin
            if (cnt_frm == LAST_FRM) begin
                if (!hold) begin
                    cnt_frm  <= '0;
                    greeting <= (greeting == LAST_MSG) ? '0 : greeting + 1'b1;
                end
            end else begin
                cnt_frm <= cnt_frm + 1'b1;
            end
        end
    end

endmodule

// File: rtl/text_fetch_ctrl.sv
// Line-triggered scheduler for the greeting and font ROMs of the text overlay.
module text_fetch_ctrl
    import text_pkg::*;
#(
    parameter int SPR_CNT      = 8,
    parameter int GREET_MSGS   = 32,
    parameter int GREET_LENGTH = 16,
    parameter int TXT_PAUSE    = 80,
    parameter int CPW          = 7,
    parameter int TXT_L1Y      = 150,
    parameter int TXT_L2Y      = 214,
    parameter int SCALE_Y      = 8,
    parameter int CORDW        = 16,
    localparam int GAW = greet_aw(GREET_MSGS, GREET_LENGTH),
    localparam int FAW = font_aw(NUM_GLYPHS, FONT_HEIGHT),
    localparam int LW  = $clog2(FONT_HEIGHT),
    localparam int GW  = $clog2(GREET_MSGS)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    frame_start,
    input  logic                    line_start,
    input  logic signed [CORDW-1:0] sy,
    input  logic                    hold,
    output logic [GAW-1:0]          greet_rom_addr,
    input  logic [CPW-1:0]          greet_rom_data,
    output logic [FAW-1:0]          font_rom_addr,
    input  logic [SPR_CNT*LW-1:0]   spr_line,
    output logic                    spr_start,
    output logic [SPR_CNT-1:0]      dma_avail,
    output logic [GW-1:0]           greeting,
    output logic                    busy,
    output logic                    overrun
);

    localparam int IW = $clog2(SPR_CNT + 1);
    localparam int JW = $clog2(SPR_CNT);
    localparam logic signed [CORDW-1:0] Y1 = CORDW'(TXT_L1Y);
    localparam logic signed [CORDW-1:0] Y2 = CORDW'(TXT_L2Y);
    localparam logic signed [CORDW-1:0] YE =
        CORDW'(TXT_L2Y + FONT_HEIGHT * SCALE_Y);

    state_t         state, state_nx;
    logic [IW-1:0]  idx, idx_nx;
    logic [JW-1:0]  jdx, cidx;
    logic [GAW-1:0] base, base_nx, base_new;
    logic [CPW-1:0] cp [SPR_CNT];
    logic [CPW-1:0] cp_in, cp_sel, gly;
    logic [LW-1:0]  line_sel;
    logic           in_band, row, take;

    msg_pacer #(
        .GREET_MSGS(GREET_MSGS),
        .TXT_PAUSE (TXT_PAUSE)
    ) u_pacer (
        .clk        (clk),
        .rst        (rst),
        .frame_start(frame_start),
        .hold       (hold),
        .greeting   (greeting)
    );

    assign in_band   = (sy >= Y1) && (sy < YE);
    assign row       = (sy >= Y2);
    assign take      = line_start && in_band;
    assign spr_start = line_start && (sy == Y1 || sy == Y2);
    assign busy      = (state != IDLE);

    assign base_new = GAW'(greeting) * GAW'(GREET_LENGTH)
                    + (row ? GAW'(GREET_LENGTH / 2) : '0);

    // out-of-font code points collapse onto the blank glyph
    assign cp_in = (int'(greet_rom_data) >= CP_START &&
                    int'(greet_rom_data) <= CP_START + NUM_GLYPHS - 1)
                 ? greet_rom_data : CPW'(CP_START);

    assign jdx      = idx[JW-1:0];
    assign cidx     = JW'(idx - 1'b1);
    assign cp_sel   = cp[jdx];
    assign line_sel = spr_line[jdx*LW +: LW];
    assign gly      = cp_sel - CPW'(CP_START);

    always_comb begin
        state_nx       = state;
        idx_nx         = idx;
        base_nx        = base;
        greet_rom_addr = '0;
        font_rom_addr  = '0;
        dma_avail      = '0;
        unique case (state)
            IDLE: begin
                if (take) begin
                    state_nx = CP;
                    idx_nx   = '0;
                    base_nx  = base_new;
                end
            end
            CP: begin
                if (idx < IW'(SPR_CNT))
                    greet_rom_addr = base + GAW'(idx);
                if (idx == IW'(SPR_CNT)) begin
                    state_nx = GLYPH;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            GLYPH: begin
                dma_avail     = SPR_CNT'(1) << jdx;
                font_rom_addr = FAW'(gly) * FAW'(FONT_HEIGHT) + FAW'(line_sel);
                if (idx == IW'(SPR_CNT - 1)) begin
                    state_nx = IDLE;
                    idx_nx   = '0;
                end else begin
                    idx_nx = idx + 1'b1;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            idx     <= '0;
            base    <= '0;
            overrun <= 1'b0;
        end else begin
            state <= state_nx;
            idx   <= idx_nx;
            base  <= base_nx;
            if (take && busy)
                overrun <= 1'b1;
        end
    end

    // ROM data lags the address by one cycle, so slot k fills cp[k-1]
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < SPR_CNT; i++)
                cp[i] <= CPW'(CP_START);
        end else if (state == CP && idx != '0) begin
            cp[cidx] <= cp_in;
        end
    end

endmodule

// File: doc/text_fetch_ctrl.md
# text_fetch_ctrl

Scheduler for the text-sprite overlay's two sync ROMs: greeting ROM for code points and font ROM for glyph lines. It replaces the fixed sx-decoded DMA slots with a line-triggered state machine. On every line inside the text band it fetches the code points for the active row, then hands each sprite its font-ROM slot in turn. It also paces the greeting selection across frames. It sits between the video timing generator and the SPR_CNT sprite instances, and drives their `start`, `dma_avail` and shared `data_in` source.

## Interface
- SPR_CNT, 8: sprites per text row.
- GREET_MSGS, 32: messages in the greeting ROM.
- GREET_LENGTH, 16: code points per message; row 2 uses offset GREET_LENGTH/2.
- TXT_PAUSE, 80: frames per message.
- FONT_HEIGHT, 8: glyph lines.
- NUM_GLYPHS, 64: glyphs in the font ROM.
- CP_START, 'h20: first code point in the font ROM.
- CPW, 7: code point width.
- TXT_L1Y, 150: first line of row 1.
- TXT_L2Y, 214: first line of row 2.
- SCALE_Y, 8: vertical glyph scale.
- CORDW, 16: signed coordinate width.

Ports:
- clk  in  1  pixel clock; the only clock.
- rst  in  1  synchronous, active-high reset.
- frame_start  in  1  one-cycle pulse per frame.
- line_start  in  1  one-cycle pulse per line, issued at least 2*SPR_CNT+2 cycles before active video.
- sy  in  CORDW signed  current line.
- hold  in  1  freezes message advance while high.
- greet_rom_addr  out  $clog2(GREET_MSGS*GREET_LENGTH)  greeting ROM address.
- greet_rom_data  in  CPW  greeting ROM data, 1-cycle latency.
- font_rom_addr  out  $clog2(NUM_GLYPHS*FONT_HEIGHT)  font ROM address.
- spr_line  in  SPR_CNT*$clog2(FONT_HEIGHT)  packed `pos` outputs of the sprites; sprite i occupies bits [i*LW +: LW].
- spr_start  out  1  start pulse to all sprites.
- dma_avail  out  SPR_CNT  one-hot font-slot grant.
- greeting  out  $clog2(GREET_MSGS)  current message index.
- busy  out  1  high while not IDLE.
- overrun  out  1  sticky error flag; cleared only by rst.

## Operation
- **Band:** TXT_L1Y ≤ sy < TXT_L2Y + FONT_HEIGHT*SCALE_Y.
- **Row select:** row = (sy ≥ TXT_L2Y). ROM base = greeting*GREET_LENGTH + row*GREET_LENGTH/2.
- **spr_start:** combinational; equals line_start && (sy==TXT_L1Y || sy==TXT_L2Y).
- **States:**
  - IDLE: on line_start with sy in band, latch base and go to CP. Otherwise stay.
  - CP: SPR_CNT+1 cycles, index k=0..SPR_CNT.
    - For k<SPR_CNT, greet_rom_addr = base+k.
    - For k≥1, cp[k-1] <= greet_rom_data.
    - After k=SPR_CNT, go to GLYPH.
  - GLYPH: SPR_CNT cycles, index j.
    - dma_avail = 1<<j.
    - font_rom_addr = (cp[j]-CP_START)*FONT_HEIGHT + spr_line[j].
    - After j=SPR_CNT-1, go to IDLE.
- **Code point range:** any cp outside [CP_START, CP_START+NUM_GLYPHS-1] is replaced by CP_START (blank glyph). The replacement is applied at capture.
- **Address widths:** all address arithmetic is unsigned and truncated to the address width. The message base wraps modulo ROM depth.
- **Outputs outside active states:** greet_rom_addr=0, font_rom_addr=0, dma_avail=0.
- **Message pacing:** cnt_frm increments on frame_start. When cnt_frm==TXT_PAUSE-1 and frame_start, cnt_frm<=0 and greeting<=greeting+1 (mod GREET_MSGS), unless hold. While hold is high, cnt_frm saturates at TXT_PAUSE-1.
- **Overrun:** a line_start in band while busy sets overrun. That line_start is otherwise ignored; the current sequence completes unchanged.
- **Frame boundary:** frame_start during CP or GLYPH is allowed. The greeting change does not alter the latched base.

## Timing
- Reset values: greet_rom_addr=0, font_rom_addr=0, dma_avail=0, spr_start=0 (given line_start=0), greeting=0, busy=0, overrun=0. Also state=IDLE, cnt_frm=0, cp[*]=CP_START.
- Reset mid-sequence: the next cycle is IDLE with all outputs at reset values. No partial grant is issued after rst.
- Cycle numbering, with line_start at cycle 0:
  - busy is high from cycle 1 through cycle 2*SPR_CNT+1 (17 at defaults).
  - greet_rom_addr = base+k at cycle 1+k.
  - cp[k] is captured at the end of cycle 2+k.
  - dma_avail[j] is high at cycle SPR_CNT+2+j (10..17 at defaults).
  - IDLE at cycle 2*SPR_CNT+2.
- Back-to-back: a line_start exactly at cycle 2*SPR_CNT+2 is accepted.
- Message change: greeting updates the cycle after the qualifying frame_start.

## Structure
- Package text_pkg holds:
  - the state enum (IDLE, CP, GLYPH);
  - CP_START, FONT_HEIGHT, NUM_GLYPHS;
  - functions for the ROM address widths.
- One sub-module, msg_pacer: cnt_frm/greeting/hold logic. Ports: clk, rst, frame_start, hold, greeting.
- The FSM and cp register file stay in text_fetch_ctrl.

## Test plan
1. **Row 1 fetch:** rst, then line_start with sy=150 and greeting=0.
   - greet_rom_addr = 0..7 on cycles 1..8.
   - dma_avail one-hot 0x01..0x80 on cycles 10..17.
   - spr_start pulses at cycle 0.
2. **Row 2 offset:** greeting=3, sy=214 → greet_rom_addr 56..63. ROM cp 'h41 with spr_line[2]=5 → font_rom_addr at cycle 12 = (0x21*8)+5 = 269.
3. **Pacing:** 80 frame_start pulses → greeting 0→1 one cycle after the 80th. 32×80 pulses → greeting wraps to 0. With hold high, greeting stays constant.
4. **Bad code point:** ROM returns 'h10 or 'h7F → corresponding font_rom_addr = spr_line value (glyph 0).
5. **Overrun and out-of-band:**
   - line_start at cycle 5 of a sequence → overrun=1 and the sequence timing is unchanged.
   - line_start with sy=100 → busy stays 0.
6. **Reset mid-GLYPH:** assert rst at cycle 12 → dma_avail=0 and busy=0 at cycle 13, and overrun=0.
